// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds the FSM state encoding and the requester count.
package ram_arbiter_pkg;

  localparam int N_REQ = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin grant: the requester not granted last wins ties.
// Ports: req (valid per requester), last_grant (index), grant (one-hot).
module ram_rr_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last_grant,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Clears a single-port RAM after reset, then arbitrates two requesters
// onto it round-robin, routing read data back with a 2-cycle latency.
// Ports: clk/rst, req_* command side, rsp_* read return, init_done,
// ram_* strobes/address/data to the RAM and ram_data_out from it.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_WORDS    = 32,
  parameter int ADDR_WIDTH = $clog2(N_WORDS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0]                    req_we,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                init_done,
  output logic                                ram_we,
  output logic                                ram_re,
  output logic [ADDR_WIDTH-1:0]               ram_address,
  output logic [DATA_WIDTH-1:0]               ram_data_in,
  input  logic [DATA_WIDTH-1:0]               ram_data_out
);

  // One extra bit so the counter can reach N_WORDS and mark the end.
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       r_clr_cnt;
  logic                   r_last_grant;
  logic                   r_ram_we;
  logic                   r_ram_re;
  logic [ADDR_WIDTH-1:0]  r_ram_address;
  logic [DATA_WIDTH-1:0]  r_ram_data_in;
  logic [N_REQ-1:0]       r_rd_id;
  logic [N_REQ-1:0]       r_rsp_valid;
  logic                   r_init_done;

  logic [N_REQ-1:0]       w_grant;
  logic                   w_clr_done;
  logic                   w_accept;
  logic                   w_sel;

  ram_rr_arbiter u_rr (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_clr_done = (r_clr_cnt == CNT_W'(N_WORDS));
  assign req_ready  = (r_state == RUN) ? w_grant : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_sel      = req_ready[1];

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && w_clr_done) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt     <= '0;
      r_last_grant  <= 1'b1;
      r_ram_we      <= 1'b0;
      r_ram_re      <= 1'b0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
      r_rd_id       <= '0;
      r_rsp_valid   <= '0;
      r_init_done   <= 1'b0;
    end else begin
      // The RAM returns data one edge after it samples ram_re.
      r_rsp_valid <= r_ram_re ? r_rd_id : '0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      if (r_state == INIT) begin
        if (!w_clr_done) begin
          r_ram_we      <= 1'b1;
          r_ram_address <= r_clr_cnt[ADDR_WIDTH-1:0];
          r_ram_data_in <= '0;
          r_clr_cnt     <= r_clr_cnt + 1'b1;
        end else begin
          r_init_done <= 1'b1;
        end
      end else if (w_accept) begin
        r_last_grant  <= w_sel;
        r_ram_we      <= req_we[w_sel];
        r_ram_re      <= ~req_we[w_sel];
        r_ram_address <= req_addr[w_sel];
        r_rd_id       <= req_ready;
        if (req_we[w_sel]) begin
          r_ram_data_in <= req_wdata[w_sel];
        end
      end
    end
  end

  assign ram_we      = r_ram_we;
  assign ram_re      = r_ram_re;
  assign ram_address = r_ram_address;
  assign ram_data_in = r_ram_data_in;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = ram_data_out;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter against a behavioural RAM
// with registered read, a vector table and a shadow memory.
module tb_ram_arbiter;

  localparam int DW = 16;
  localparam int NW = 32;
  localparam int AW = 5;
  localparam int NV = 14;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [1:0]          req_we = '0;
  logic [1:0][AW-1:0]  req_addr = '0;
  logic [1:0][DW-1:0]  req_wdata = '0;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                init_done;
  logic                ram_we;
  logic                ram_re;
  logic [AW-1:0]       ram_address;
  logic [DW-1:0]       ram_data_in;
  logic [DW-1:0]       ram_data_out = '0;

  logic [DW-1:0] mem [NW];

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter #(.DATA_WIDTH(DW), .N_WORDS(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .init_done    (init_done),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
    if (ram_re) ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]    v;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    rdy;
    logic          rwe;
    logic          rre;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdin;
    logic [1:0]    rsp;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t tbl [NV];

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] shadow [NW];
  logic [1:0]    held;

  task automatic drive(input vec_t t);
    req_valid    = t.v;
    req_we       = t.we;
    req_addr[0]  = t.a0;
    req_addr[1]  = t.a1;
    req_wdata[0] = t.d0;
    req_wdata[1] = t.d1;
  endtask

  initial begin
    tbl[0]  = '{2'b10, 2'b10, 5'd0,  5'd31, 16'h0000, 16'h1234,
                2'b10, 1'b1, 1'b0, 5'd31, 16'h1234, 2'b00, 16'h0000};
    tbl[1]  = '{2'b01, 2'b00, 5'd31, 5'd0,  16'h0000, 16'h0000,
                2'b01, 1'b0, 1'b1, 5'd31, 16'h0000, 2'b01, 16'h1234};
    tbl[2]  = '{2'b10, 2'b10, 5'd0,  5'd3,  16'h0000, 16'h0333,
                2'b10, 1'b1, 1'b0, 5'd3,  16'h0333, 2'b00, 16'h0000};
    tbl[3]  = '{2'b10, 2'b10, 5'd0,  5'd7,  16'h0000, 16'h0777,
                2'b10, 1'b1, 1'b0, 5'd7,  16'h0777, 2'b00, 16'h0000};
    tbl[4]  = '{2'b11, 2'b00, 5'd3,  5'd7,  16'h0000, 16'h0000,
                2'b01, 1'b0, 1'b1, 5'd3,  16'h0000, 2'b01, 16'h0333};
    tbl[5]  = '{2'b11, 2'b00, 5'd3,  5'd7,  16'h0000, 16'h0000,
                2'b10, 1'b0, 1'b1, 5'd7,  16'h0000, 2'b10, 16'h0777};
    tbl[6]  = '{2'b11, 2'b00, 5'd3,  5'd7,  16'h0000, 16'h0000,
                2'b01, 1'b0, 1'b1, 5'd3,  16'h0000, 2'b01, 16'h0333};
    tbl[7]  = '{2'b11, 2'b00, 5'd3,  5'd7,  16'h0000, 16'h0000,
                2'b10, 1'b0, 1'b1, 5'd7,  16'h0000, 2'b10, 16'h0777};
    tbl[8]  = '{2'b01, 2'b01, 5'd5,  5'd0,  16'hBEEF, 16'h0000,
                2'b01, 1'b1, 1'b0, 5'd5,  16'hBEEF, 2'b00, 16'h0000};
    tbl[9]  = '{2'b01, 2'b00, 5'd5,  5'd0,  16'h0000, 16'h0000,
                2'b01, 1'b0, 1'b1, 5'd5,  16'h0000, 2'b01, 16'hBEEF};
    tbl[10] = '{2'b00, 2'b00, 5'd0,  5'd0,  16'h0000, 16'h0000,
                2'b00, 1'b0, 1'b0, 5'd5,  16'h0000, 2'b00, 16'h0000};
    tbl[11] = '{2'b10, 2'b00, 5'd0,  5'd5,  16'h0000, 16'h0000,
                2'b10, 1'b0, 1'b1, 5'd5,  16'h0000, 2'b10, 16'hBEEF};
    tbl[12] = '{2'b11, 2'b11, 5'd1,  5'd2,  16'h1111, 16'h2222,
                2'b01, 1'b1, 1'b0, 5'd1,  16'h1111, 2'b00, 16'h0000};
    tbl[13] = '{2'b00, 2'b00, 5'd0,  5'd0,  16'h0000, 16'h0000,
                2'b00, 1'b0, 1'b0, 5'd1,  16'h0000, 2'b00, 16'h0000};

    // Reset state, with both requesters asking
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_re", ram_re, 0);
    chk("rst addr", ram_address, 0);
    chk("rst din", ram_data_in, 0);
    chk("rst init_done", init_done, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst ready", req_ready, 0);
    rst = 1'b0;

    // Clear sweep
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      chk($sformatf("clr%0d we", k), ram_we, 1);
      chk($sformatf("clr%0d addr", k), ram_address, k);
      chk($sformatf("clr%0d din", k), ram_data_in, 0);
      chk($sformatf("clr%0d ready", k), req_ready, 0);
      chk($sformatf("clr%0d init_done", k), init_done, 0);
    end
    @(negedge clk);
    chk("init_done rise", init_done, 1);
    chk("init end we", ram_we, 0);
    chk("first tie ready", req_ready, 2'b01);
    req_valid = 2'b00;

    // Vector table, pipelined: ready now, ram next, rsp after that
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i < NV) drive(tbl[i]);
      else req_valid = 2'b00;
      #1;
      if (i < NV)
        chk($sformatf("v%0d ready", i), req_ready, tbl[i].rdy);
      if (i >= 1 && i - 1 < NV) begin
        chk($sformatf("v%0d ram_we", i - 1), ram_we, tbl[i-1].rwe);
        chk($sformatf("v%0d ram_re", i - 1), ram_re, tbl[i-1].rre);
        chk($sformatf("v%0d addr", i - 1), ram_address, tbl[i-1].radr);
        if (tbl[i-1].rwe)
          chk($sformatf("v%0d din", i - 1), ram_data_in, tbl[i-1].rdin);
      end
      if (i >= 2) begin
        chk($sformatf("v%0d rsp_valid", i - 2), rsp_valid, tbl[i-2].rsp);
        if (tbl[i-2].rsp != 2'b00)
          chk($sformatf("v%0d rdata", i - 2), rsp_rdata, tbl[i-2].rdat);
      end
    end

    // Reset one edge after a read is accepted
    @(negedge clk);
    req_valid   = 2'b01;
    req_we      = 2'b00;
    req_addr[0] = 5'd5;
    #1;
    chk("rr ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("rr ram_re", ram_re, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr rsp_valid", rsp_valid, 0);
    chk("rr init_done", init_done, 0);
    chk("rr ram_re", ram_re, 0);
    chk("rr addr", ram_address, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rr rsp_valid2", rsp_valid, 0);
    chk("rr clr0 we", ram_we, 1);
    chk("rr clr0 addr", ram_address, 0);
    @(negedge clk);
    chk("rr clr1 addr", ram_address, 1);
    begin
      int n;
      n = 0;
      while (!init_done && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rr init timeout", init_done, 1);
    end

    // Random traffic against a shadow memory
    for (int a = 0; a < NW; a++) shadow[a] = '0;
    held = 2'b00;
    for (int c = 0; c < 203; c++) begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == c) begin
        chk($sformatf("rnd c%0d rsp_valid", c), rsp_valid, q[0].id);
        chk($sformatf("rnd c%0d rdata", c), rsp_rdata, q[0].data);
        void'(q.pop_front());
      end else begin
        chk($sformatf("rnd c%0d idle rsp", c), rsp_valid, 0);
      end
      chk($sformatf("rnd c%0d we&re", c), ram_we & ram_re, 0);
      for (int r = 0; r < 2; r++) begin
        if (!held[r]) begin
          req_valid[r] = (c < 200) && ($urandom_range(0, 3) != 0);
          req_we[r]    = $urandom_range(0, 1) == 1;
          req_addr[r]  = AW'($urandom_range(0, NW - 1));
          req_wdata[r] = DW'($urandom);
        end
      end
      #1;
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          if (req_we[r]) shadow[req_addr[r]] = req_wdata[r];
          else q.push_back('{2'b01 << r, shadow[req_addr[r]], c + 2});
          held[r] = 1'b0;
        end else begin
          held[r] = req_valid[r];
        end
      end
    end
    chk("rnd queue drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, RAM word width; N_WORDS, default 32, RAM depth; ADDR_WIDTH, default $clog2(N_WORDS), address width.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  2  per-requester command valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester command accepted this cycle.
REQ-006 req_we  input  2  per-requester command type: 1 = write, 0 = read.
REQ-007 req_addr  input  2 x ADDR_WIDTH  per-requester address.
REQ-008 req_wdata  input  2 x DATA_WIDTH  per-requester write data.
REQ-009 rsp_valid  output  2  per-requester read-data valid pulse.
REQ-010 rsp_rdata  output  DATA_WIDTH  shared read data, meaningful only while some rsp_valid bit is high.
REQ-011 init_done  output  1  high once the post-reset RAM clear has completed.
REQ-012 ram_we, ram_re  output  1 each  RAM write and read strobes.
REQ-013 ram_address  output  ADDR_WIDTH  RAM address.
REQ-014 ram_data_in  output  DATA_WIDTH  RAM write data.
REQ-015 ram_data_out  input  DATA_WIDTH  RAM read data, registered by the RAM one edge after the edge that samples ram_re.

Function
REQ-016 The FSM SHALL have two states: INIT and RUN. Reset SHALL enter INIT.
REQ-017 In INIT, the block SHALL write 0 to addresses 0..N_WORDS-1, one per cycle, in ascending order, using a clear counter.
- req_ready SHALL be 00.
- On the cycle after address N_WORDS-1 is written, the FSM SHALL move to RUN and init_done SHALL go high.
REQ-018 In RUN, at most one requester SHALL be granted per cycle; req_ready[i] SHALL be combinational: RUN && req_valid[i] && grant to i.
REQ-019 Arbitration SHALL be round-robin.
- If only one requester is valid, it is granted.
- If both are valid, the requester not granted last SHALL win.
- last_grant SHALL update only on an acceptance.
REQ-020 A command SHALL be accepted on an edge where req_valid[i] && req_ready[i] are both high. Requesters SHALL hold their command stable until acceptance; the block SHALL not check this.
REQ-021 An accepted command SHALL be registered onto the ram_* outputs for exactly the one following cycle; ram_we and ram_re SHALL never be high together.
REQ-022 Read latency: for a read accepted at edge N, rsp_valid[i] SHALL be high for exactly the cycle after edge N+1, with rsp_rdata = ram_data_out.
REQ-023 Writes SHALL produce no response.
REQ-024 Throughput SHALL be one command per cycle; back-to-back reads SHALL yield back-to-back rsp_valid pulses in acceptance order.
REQ-025 A read following a write to the same address on the next cycle SHALL return the new data, relying on RAM write-then-read ordering.
REQ-026 When no command is accepted, ram_we and ram_re SHALL be 0; ram_address and ram_data_in SHALL hold their last values.

Reset
REQ-027 While rst is sampled high, the following SHALL be forced at that edge: FSM=INIT, clear counter=0, last_grant=1 (requester 0 wins the first tie), ram_we=0, ram_re=0, ram_address=0, ram_data_in=0, rsp_valid=00, init_done=0.
REQ-028 Reset during RUN SHALL discard any in-flight read response and restart the full clear from address 0.

Structure
REQ-029 Package ram_arbiter_pkg SHALL hold the FSM state enum (INIT, RUN) and the constant N_REQ = 2.
REQ-030 Round-robin grant logic SHALL live in sub-module ram_rr_arbiter: inputs req[1:0] and last_grant; output one-hot grant[1:0].

Verification
REQ-031 Release reset: expect ram_we=1 for 32 consecutive cycles with addresses 0..31 and data 0; init_done rises on the 33rd cycle; req_ready stays 00 throughout.
REQ-032 Requester 0 writes 0xBEEF to address 5, then reads address 5: expect rsp_valid=01 and rsp_rdata=0xBEEF two edges after the read is accepted.
REQ-033 Both requesters hold valid reads of addresses 3 and 7 continuously: expect grants alternating 0,1,0,1 starting with 0; responses alternate rsp_valid 01/10, one per cycle.
REQ-034 Requester 1 writes 0x1234 to address 31, and requester 0 reads address 31 on the next cycle: expect 0x1234 returned.
REQ-035 Assert rst for one cycle one edge after a read is accepted: expect no rsp_valid pulse, init_done=0, and the clear restarting at address 0.
REQ-036 Random traffic of 200 cycles, compared against a shadow memory: every rsp_rdata matches, and ram_we and ram_re are never high together.
